leaf_out_credit_arbiter: RTL and testbench

Output-side stage of a leaf interface. It merges NUM_OUT_PORTS user output streams onto the single BFT output link using a round-robin arbiter. Each port has credit-based flow control against the destination BRAM buffer and its own wrapping write-address counter. It honours the BFT resend back-pressure and replaces the fixed single-port output path with a parametrised multi-port one.

---
 rtl/leaf_pkt_pkg.sv | 50 +++++
 rtl/leaf_rr_arbiter.sv | 48 ++++
 rtl/leaf_out_credit_arbiter.sv | 144 ++++++++++++++
 tb/tb_leaf_out_credit_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/leaf_pkt_pkg.sv
// Packet layout helpers shared by the leaf output path.
// Provides field widths/offsets for {valid,leaf,port,addr,payload} (MSB first),
// an index-width helper and a pack function working on a wide scratch vector.
package leaf_pkt_pkg;

  // Scratch width for packing; every field and the full packet must fit in it.
  localparam int PKT_WIDE_BITS = 128;
  typedef logic [PKT_WIDE_BITS-1:0] pkt_wide_t;

  // Width of an index able to address n entries (at least one bit).
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int pkt_bits(input int leaf_w, input int port_w,
                                  input int addr_w, input int pay_w);
    return 1 + leaf_w + port_w + addr_w + pay_w;
  endfunction

  function automatic int off_addr(input int pay_w);
    return pay_w;
  endfunction

  function automatic int off_port(input int addr_w, input int pay_w);
    return pay_w + addr_w;
  endfunction

  function automatic int off_leaf(input int port_w, input int addr_w, input int pay_w);
    return pay_w + addr_w + port_w;
  endfunction

  function automatic int off_valid(input int leaf_w, input int port_w,
                                   input int addr_w, input int pay_w);
    return pay_w + addr_w + port_w + leaf_w;
  endfunction

  // Fields arrive zero-extended to the scratch width; the caller truncates
  // the result to the real packet width.
  function automatic pkt_wide_t pkt_pack(input logic valid, input pkt_wide_t leaf,
                                         input pkt_wide_t port, input pkt_wide_t addr,
                                         input pkt_wide_t payload, input int leaf_w,
                                         input int port_w, input int addr_w, input int pay_w);
    return payload
         | (addr << off_addr(pay_w))
         | (port << off_port(addr_w, pay_w))
         | (leaf << off_leaf(port_w, addr_w, pay_w))
         | (pkt_wide_t'(valid) << off_valid(leaf_w, port_w, addr_w, pay_w));
  endfunction

endpackage

// File: rtl/leaf_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the pointer.
// Ports: clk/reset (sync, active-high), i_req[N] requests, i_advance lets the
// pointer move to the granted index, o_grant[N] combinational one-hot grant.
module leaf_rr_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_req,
  input  logic         i_advance,
  output logic [N-1:0] o_grant
);

  localparam int PB = idx_bits(N);

  logic [PB-1:0] r_ptr;
  logic [PB-1:0] w_idx;
  logic          w_found;

  // Search starts one past the last winner, so that winner has lowest priority.
  always_comb begin
    int idx;
    o_grant = '0;
    w_idx   = r_ptr;
    w_found = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && i_req[idx]) begin
        w_found      = 1'b1;
        o_grant[idx] = 1'b1;
        w_idx        = PB'(idx);
      end
    end
  end

  // Reset to N-1 so port 0 wins first; with N=1 this stays 0 forever.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PB'(N - 1);
    end else if (i_advance && w_found) begin
      r_ptr <= w_idx;
    end
  end

endmodule

// File: rtl/leaf_out_credit_arbiter.sv
// Leaf output stage: round-robin merge of user ports onto one BFT link,
// with per-port destination config, wrapping write address and credit count.
// Ports: per-port vld/din in, ack out; registered packet dout; resend holds it;
// cfg_* programs a port; credit_ret_* returns buffer space; credit_err sticky.
module leaf_out_credit_arbiter
  import leaf_pkt_pkg::*;
#(
  parameter int PAYLOAD_BITS       = 32,
  parameter int NUM_LEAF_BITS      = 3,
  parameter int NUM_PORT_BITS      = 4,
  parameter int NUM_ADDR_BITS      = 7,
  parameter int NUM_BRAM_ADDR_BITS = 7,
  parameter int NUM_OUT_PORTS      = 4,
  localparam int PACKET_BITS = pkt_bits(NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS),
  localparam int CREDIT_BITS = NUM_BRAM_ADDR_BITS + 1,
  localparam int PIDX_BITS   = idx_bits(NUM_OUT_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
  input  logic [PAYLOAD_BITS*NUM_OUT_PORTS-1:0] din_leaf_user2interface,
  output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
  output logic [PACKET_BITS-1:0]                dout_leaf_interface2bft,
  input  logic                                  resend,
  input  logic                                  cfg_wr,
  input  logic [PIDX_BITS-1:0]                  cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]              cfg_dst_leaf,
  input  logic [NUM_PORT_BITS-1:0]              cfg_dst_port,
  input  logic                                  cfg_enable,
  input  logic                                  credit_ret_vld,
  input  logic [PIDX_BITS-1:0]                  credit_ret_port,
  input  logic [CREDIT_BITS-1:0]                credit_ret_amount,
  output logic [NUM_OUT_PORTS-1:0]              credit_err
);

  localparam int SUM_BITS = CREDIT_BITS + 1;
  localparam logic [CREDIT_BITS-1:0] CREDIT_MAX = {1'b1, {NUM_BRAM_ADDR_BITS{1'b0}}};

  logic                          r_enable   [NUM_OUT_PORTS];
  logic [NUM_LEAF_BITS-1:0]      r_dst_leaf [NUM_OUT_PORTS];
  logic [NUM_PORT_BITS-1:0]      r_dst_port [NUM_OUT_PORTS];
  logic [NUM_BRAM_ADDR_BITS-1:0] r_addr     [NUM_OUT_PORTS];
  logic [CREDIT_BITS-1:0]        r_credit   [NUM_OUT_PORTS];
  logic [NUM_OUT_PORTS-1:0]      r_credit_err;
  logic [PACKET_BITS-1:0]        r_dout;

  logic [NUM_OUT_PORTS-1:0] w_cfg_hit;
  logic [NUM_OUT_PORTS-1:0] w_eligible;
  logic [NUM_OUT_PORTS-1:0] w_req;
  logic [NUM_OUT_PORTS-1:0] w_grant;
  logic [NUM_OUT_PORTS-1:0] w_ret_hit;
  logic [NUM_OUT_PORTS-1:0] w_ovf;
  logic [SUM_BITS-1:0]      w_sum [NUM_OUT_PORTS];
  logic [PIDX_BITS-1:0]     w_sel;
  logic [PACKET_BITS-1:0]   w_pkt;

  // A port being reconfigured this cycle must not send with stale settings.
  always_comb begin
    w_cfg_hit  = '0;
    w_eligible = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_cfg_hit[i]  = cfg_wr && (cfg_port == PIDX_BITS'(i));
      w_eligible[i] = r_enable[i] && vld_user2interface[i] &&
                      (r_credit[i] != '0) && !w_cfg_hit[i];
    end
  end

  // Resend freezes arbitration entirely, including the pointer.
  assign w_req = resend ? '0 : w_eligible;

  leaf_rr_arbiter #(.N(NUM_OUT_PORTS)) u_rr (
    .clk       (clk),
    .reset     (reset),
    .i_req     (w_req),
    .i_advance (!resend),
    .o_grant   (w_grant)
  );

  assign ack_interface2user      = (reset || resend) ? '0 : w_grant;
  assign dout_leaf_interface2bft = r_dout;
  assign credit_err              = r_credit_err;

  // Net credit change: return and grant on the same port combine before the
  // saturation test, one bit wider than the counter so overflow is visible.
  always_comb begin
    w_ret_hit = '0;
    w_ovf     = '0;
    w_sel     = '0;
    for (int i = 0; i < NUM_OUT_PORTS; i++) begin
      w_ret_hit[i] = credit_ret_vld && (credit_ret_port == PIDX_BITS'(i)) &&
                     (credit_ret_amount != '0);
      w_sum[i]     = {1'b0, r_credit[i]}
                   + (w_ret_hit[i] ? {1'b0, credit_ret_amount} : SUM_BITS'(0))
                   - SUM_BITS'(w_grant[i]);
      w_ovf[i]     = w_sum[i] > {1'b0, CREDIT_MAX};
      if (w_grant[i]) begin
        w_sel = PIDX_BITS'(i);
      end
    end
    w_pkt = PACKET_BITS'(pkt_pack(1'b1,
                                  pkt_wide_t'(r_dst_leaf[w_sel]),
                                  pkt_wide_t'(r_dst_port[w_sel]),
                                  pkt_wide_t'(r_addr[w_sel]),
                                  pkt_wide_t'(din_leaf_user2interface[int'(w_sel)*PAYLOAD_BITS +: PAYLOAD_BITS]),
                                  NUM_LEAF_BITS, NUM_PORT_BITS, NUM_ADDR_BITS, PAYLOAD_BITS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dout       <= '0;
      r_credit_err <= '0;
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        r_enable[i]   <= 1'b0;
        r_dst_leaf[i] <= '0;
        r_dst_port[i] <= '0;
        r_addr[i]     <= '0;
        r_credit[i]   <= CREDIT_MAX;
      end
    end else begin
      if (!resend) begin
        r_dout <= (|w_grant) ? w_pkt : '0;
      end
      for (int i = 0; i < NUM_OUT_PORTS; i++) begin
        if (w_cfg_hit[i]) begin
          // Config wins over a same-cycle credit return; the error flag is kept.
          r_enable[i]   <= cfg_enable;
          r_dst_leaf[i] <= cfg_dst_leaf;
          r_dst_port[i] <= cfg_dst_port;
          r_addr[i]     <= '0;
          r_credit[i]   <= CREDIT_MAX;
        end else begin
          if (w_grant[i]) begin
            r_addr[i] <= r_addr[i] + NUM_BRAM_ADDR_BITS'(1);
          end
          r_credit[i] <= w_ovf[i] ? CREDIT_MAX : w_sum[i][CREDIT_BITS-1:0];
          if (w_ovf[i]) begin
            r_credit_err[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_leaf_out_credit_arbiter.sv
module tb_leaf_out_credit_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   vld;
  logic [31:0]  din [4];
  logic [127:0] din_bus;
  logic [3:0]   ack;
  logic [46:0]  dout;
  logic         resend;
  logic         cfg_wr;
  logic [1:0]   cfg_port;
  logic [2:0]   cfg_dst_leaf;
  logic [3:0]   cfg_dst_port;
  logic         cfg_enable;
  logic         credit_ret_vld;
  logic [1:0]   credit_ret_port;
  logic [7:0]   credit_ret_amount;
  logic [3:0]   credit_err;

  assign din_bus = {din[3], din[2], din[1], din[0]};

  always #5 clk = ~clk;

  leaf_out_credit_arbiter #(
    .PAYLOAD_BITS(32), .NUM_LEAF_BITS(3), .NUM_PORT_BITS(4),
    .NUM_ADDR_BITS(7), .NUM_BRAM_ADDR_BITS(7), .NUM_OUT_PORTS(4)
  ) dut (
    .clk(clk), .reset(reset),
    .vld_user2interface(vld), .din_leaf_user2interface(din_bus),
    .ack_interface2user(ack), .dout_leaf_interface2bft(dout),
    .resend(resend),
    .cfg_wr(cfg_wr), .cfg_port(cfg_port), .cfg_dst_leaf(cfg_dst_leaf),
    .cfg_dst_port(cfg_dst_port), .cfg_enable(cfg_enable),
    .credit_ret_vld(credit_ret_vld), .credit_ret_port(credit_ret_port),
    .credit_ret_amount(credit_ret_amount), .credit_err(credit_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-port state as plain integers, round robin as a
  // "last winner" index searched forward with modulo arithmetic.
  bit         m_en     [4];
  logic [2:0] m_leaf   [4];
  logic [3:0] m_port   [4];
  int         m_addr   [4];
  int         m_credit [4];
  logic [3:0] m_err;
  int         m_last;
  int         m_g;
  logic [46:0] m_dout;

  logic [3:0]  e_ack, o_ack, o_err;
  logic [46:0] o_dout;

  function automatic bit m_elig(int j);
    return m_en[j] && vld[j] && (m_credit[j] > 0) && !(cfg_wr && (int'(cfg_port) == j));
  endfunction

  task automatic model_comb();
    m_g = -1;
    if (!reset && !resend)
      for (int k = 1; k <= 4; k++)
        if (m_g < 0 && m_elig((m_last + k) % 4)) m_g = (m_last + k) % 4;
    e_ack = (m_g >= 0) ? 4'(1 << m_g) : 4'b0;
  endtask

  task automatic model_update();
    int p;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_en[i] = 0; m_leaf[i] = 0; m_port[i] = 0; m_addr[i] = 0; m_credit[i] = 128;
      end
      m_err = 0; m_last = 3; m_dout = 0;
    end else begin
      if (!resend)
        m_dout = (m_g >= 0) ? {1'b1, m_leaf[m_g], m_port[m_g], 7'(m_addr[m_g]), din[m_g]} : 47'd0;
      if (m_g >= 0) begin
        m_addr[m_g] = (m_addr[m_g] + 1) % 128;
        m_credit[m_g] = m_credit[m_g] - 1;
        m_last = m_g;
      end
      p = int'(credit_ret_port);
      if (credit_ret_vld && credit_ret_amount != 0 && !(cfg_wr && cfg_port == credit_ret_port)) begin
        m_credit[p] = m_credit[p] + int'(credit_ret_amount);
        if (m_credit[p] > 128) begin
          m_credit[p] = 128;
          m_err[p] = 1'b1;
        end
      end
      if (cfg_wr) begin
        p = int'(cfg_port);
        m_en[p] = cfg_enable; m_leaf[p] = cfg_dst_leaf; m_port[p] = cfg_dst_port;
        m_addr[p] = 0; m_credit[p] = 128;
      end
    end
  endtask

  // One clock: ack sampled mid-cycle, dout/err sampled 1 ns after the edge.
  task automatic tick();
    #2;
    model_comb();
    o_ack = ack;
    @(posedge clk);
    model_update();
    #1;
    o_dout = dout;
    o_err  = credit_err;
  endtask

  task automatic idle();
    reset = 0; vld = 0; resend = 0; cfg_wr = 0; cfg_port = 0; cfg_dst_leaf = 0;
    cfg_dst_port = 0; cfg_enable = 0; credit_ret_vld = 0; credit_ret_port = 0;
    credit_ret_amount = 0;
    for (int i = 0; i < 4; i++) din[i] = $urandom;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic do_cfg(int p, int leaf, int port, bit en);
    cfg_wr = 1; cfg_port = 2'(p); cfg_dst_leaf = 3'(leaf); cfg_dst_port = 4'(port);
    cfg_enable = en;
    tick();
    cfg_wr = 0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1; vld = 4'hF;
    tick(); tick();
    n_tests++; if (o_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack got %b want 0000", o_ack); end
    n_tests++; if (o_dout !== 47'd0) begin n_fail++; $display("FAIL reset_dout got %h want 0", o_dout); end
    n_tests++; if (o_err !== 4'b0) begin n_fail++; $display("FAIL reset_err got %b want 0000", o_err); end
    idle();
  endtask

  task automatic test_single_port();
    logic [46:0] want;
    do_cfg(0, 5, 2, 1);
    for (int k = 0; k < 3; k++) begin
      vld = 4'b0001; din[0] = 32'hA0 + 32'(k);
      tick();
      want = {1'b1, 3'd5, 4'd2, 7'(k), 32'(32'hA0 + k)};
      n_tests++;
      if (o_ack !== 4'b0001 || o_ack !== e_ack) begin
        n_fail++; $display("FAIL single_ack k=%0d got %b want 0001", k, o_ack);
      end
      n_tests++;
      if (o_dout !== want || o_dout !== m_dout) begin
        n_fail++; $display("FAIL single_dout k=%0d got %h want %h", k, o_dout, want);
      end
    end
    vld = 0;
    tick();
    n_tests++; if (o_dout !== 47'd0) begin n_fail++; $display("FAIL single_idle dout got %h want 0", o_dout); end
  endtask

  task automatic test_round_robin();
    logic [3:0] want;
    do_reset();
    for (int p = 0; p < 4; p++) do_cfg(p, p + 1, p + 4, 1);
    for (int c = 0; c < 8; c++) begin
      vld = 4'hF;
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      tick();
      want = 4'(1 << (c % 4));
      n_tests++;
      if (o_ack !== want || o_ack !== e_ack || $countones(o_ack) != 1) begin
        n_fail++; $display("FAIL rr_order c=%0d got %b want %b", c, o_ack, want);
      end
      n_tests++;
      if (o_dout !== m_dout) begin n_fail++; $display("FAIL rr_dout c=%0d got %h want %h", c, o_dout, m_dout); end
    end
    idle();
  endtask

  task automatic test_credit_wrap();
    int acks = 0;
    bit first = 1;
    do_reset();
    do_cfg(1, 3, 9, 1);
    for (int c = 0; c < 130; c++) begin
      vld = 4'b0010; din[1] = $urandom;
      tick();
      if (o_ack[1]) acks++;
      n_tests++;
      if (o_ack !== e_ack || o_dout !== m_dout || (c >= 128 && o_ack !== 4'b0)) begin
        n_fail++; $display("FAIL wrap_stream c=%0d ack %b/%b dout %h/%h", c, o_ack, e_ack, o_dout, m_dout);
      end
    end
    n_tests++; if (acks != 128) begin n_fail++; $display("FAIL wrap_count got %0d want 128", acks); end
    credit_ret_vld = 1; credit_ret_port = 2'd1; credit_ret_amount = 8'd4;
    tick();
    credit_ret_vld = 0;
    n_tests++; if (o_ack !== 4'b0) begin n_fail++; $display("FAIL wrap_empty_ack got %b want 0000", o_ack); end
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      din[1] = $urandom;
      tick();
      if (o_ack[1]) begin
        acks++;
        if (first) begin
          first = 0;
          n_tests++;
          if (o_dout[38:32] !== 7'd0 || o_dout[46] !== 1'b1) begin
            n_fail++; $display("FAIL wrap_addr got %h want addr 0 valid 1", o_dout[46:32]);
          end
        end
      end
      n_tests++;
      if (o_ack !== e_ack || o_dout !== m_dout) begin
        n_fail++; $display("FAIL wrap_refill c=%0d ack %b/%b dout %h/%h", c, o_ack, e_ack, o_dout, m_dout);
      end
    end
    n_tests++; if (acks != 4) begin n_fail++; $display("FAIL wrap_refill_count got %0d want 4", acks); end
    idle();
  endtask

  task automatic test_resend();
    logic [46:0] held;
    do_reset();
    do_cfg(0, 6, 1, 1);
    vld = 4'b0001; din[0] = 32'h1111_0000;
    tick();
    held = o_dout;
    n_tests++; if (held[38:32] !== 7'd0 || held[46] !== 1'b1) begin n_fail++; $display("FAIL resend_first got %h want addr 0", held); end
    resend = 1;
    for (int c = 0; c < 3; c++) begin
      din[0] = $urandom;
      tick();
      n_tests++;
      if (o_ack !== 4'b0 || o_dout !== held || o_dout !== m_dout) begin
        n_fail++; $display("FAIL resend_hold c=%0d ack %b dout %h want %h", c, o_ack, o_dout, held);
      end
    end
    resend = 0; din[0] = 32'h2222_0000;
    tick();
    n_tests++;
    if (o_ack !== 4'b0001 || o_dout !== {1'b1, 3'd6, 4'd1, 7'd1, 32'h2222_0000}) begin
      n_fail++; $display("FAIL resend_next ack %b dout %h want addr 1", o_ack, o_dout);
    end
    idle();
  endtask

  task automatic test_credit_overflow();
    do_reset();
    do_cfg(2, 1, 1, 1);
    credit_ret_vld = 1; credit_ret_port = 2'd2; credit_ret_amount = 8'd1;
    tick();
    credit_ret_vld = 0;
    n_tests++; if (o_err !== 4'b0100 || o_err !== m_err) begin n_fail++; $display("FAIL ovf_set got %b want 0100", o_err); end
    do_cfg(2, 3, 3, 1);
    n_tests++; if (o_err !== 4'b0100) begin n_fail++; $display("FAIL ovf_sticky got %b want 0100", o_err); end
    vld = 4'b0100;
    tick();
    n_tests++; if (o_ack !== 4'b0100 || o_dout !== m_dout) begin n_fail++; $display("FAIL ovf_full_send ack %b dout %h", o_ack, o_dout); end
    vld = 0;
    do_reset();
    n_tests++; if (o_err !== 4'b0) begin n_fail++; $display("FAIL ovf_clear got %b want 0000", o_err); end
  endtask

  task automatic test_same_cycle();
    int acks = 0;
    do_reset();
    do_cfg(3, 2, 7, 1);
    vld = 4'b1000;
    cfg_wr = 1; cfg_port = 2'd3; cfg_dst_leaf = 3'd2; cfg_dst_port = 4'd7; cfg_enable = 1;
    tick();
    cfg_wr = 0;
    n_tests++; if (o_ack !== 4'b0) begin n_fail++; $display("FAIL cfg_block_ack got %b want 0000", o_ack); end
    for (int c = 0; c < 118; c++) begin
      din[3] = $urandom;
      tick();
      n_tests++;
      if (o_ack !== 4'b1000 || o_dout !== m_dout) begin
        n_fail++; $display("FAIL same_drain c=%0d ack %b dout %h/%h", c, o_ack, o_dout, m_dout);
      end
    end
    credit_ret_vld = 1; credit_ret_port = 2'd3; credit_ret_amount = 8'd2;
    tick();
    credit_ret_vld = 0;
    n_tests++; if (o_ack !== 4'b1000) begin n_fail++; $display("FAIL same_grant got %b want 1000", o_ack); end
    for (int c = 0; c < 14; c++) begin
      tick();
      if (o_ack[3]) acks++;
    end
    n_tests++; if (acks != 11) begin n_fail++; $display("FAIL same_net_credit got %0d grants want 11", acks); end
    idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int p = 0; p < 4; p++) do_cfg(p, $urandom_range(0, 7), $urandom_range(0, 15), 1);
    for (int c = 0; c < 400; c++) begin
      vld = 4'($urandom);
      for (int i = 0; i < 4; i++) din[i] = $urandom;
      resend = ($urandom_range(0, 7) == 0);
      credit_ret_vld = ($urandom_range(0, 2) == 0);
      credit_ret_port = 2'($urandom_range(0, 3));
      credit_ret_amount = 8'($urandom_range(0, 9));
      cfg_wr = ($urandom_range(0, 31) == 0);
      cfg_port = 2'($urandom_range(0, 3));
      cfg_dst_leaf = 3'($urandom);
      cfg_dst_port = 4'($urandom);
      cfg_enable = ($urandom_range(0, 3) != 0);
      tick();
      n_tests++;
      if (o_ack !== e_ack || o_dout !== m_dout || o_err !== m_err) begin
        n_fail++;
        $display("FAIL rand c=%0d ack %b/%b dout %h/%h err %b/%b", c, o_ack, e_ack, o_dout, m_dout, o_err, m_err);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_credit_wrap();
    test_resend();
    test_credit_overflow();
    test_same_cycle();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
